// File: rtl/ddr_cmd_dispatch.sv
// ddr_cmd_dispatch: pops DDR request FIFOs and drives the MIG app interface.
// Optional statistics counters: define DDR_DISPATCH_STATS_EN.
module ddr_cmd_dispatch #(
   parameter int WR_BURST_MAX = 8,
   parameter int ADDR_W       = 27
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [ADDR_W-1:0] wr_adx_in,
   input  logic [127:0]      wr_data_in,
   input  logic              has_wr_adx,
   input  logic              has_wr_data,
   output logic              get_wr_adx,
   output logic              get_wr_data,
   input  logic [ADDR_W-1:0] rd_adx_in,
   input  logic              has_rd_req,
   output logic              get_rd_req,
   output logic [ADDR_W-1:0] app_addr,
   output logic [2:0]        app_cmd,
   output logic              app_en,
   input  logic              app_rdy,
   output logic [63:0]       app_wdf_data,
   output logic [7:0]        app_wdf_mask,
   output logic              app_wdf_wren,
   output logic              app_wdf_end,
   input  logic              app_wdf_rdy,
   output logic              busy
`ifdef DDR_DISPATCH_STATS_EN
  ,output logic [31:0]       stat_wr_cnt,
   output logic [31:0]       stat_rd_cnt,
   output logic [31:0]       stat_stall_cnt
`endif
);

   typedef enum logic [2:0] {
      IDLE,
      WR_D0,
      WR_D1,
      WR_CMD,
      RD_CMD
   } state_t;

   localparam logic [7:0] MAX_V = 8'(WR_BURST_MAX);

   state_t     state, state_nx;
   logic [7:0] wr_streak, streak_nx;
   logic       wr_ok, rd_ok, wr_room;

   assign wr_ok   = has_wr_adx & has_wr_data;
   assign rd_ok   = has_rd_req;
   assign wr_room = wr_streak < MAX_V;

   // State and write-streak registers
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state     <= IDLE;
         wr_streak <= 8'd0;
      end else begin
         state     <= state_nx;
         wr_streak <= streak_nx;
      end
   end

   // Next-state: arbitration in IDLE, handshake progress elsewhere
   always_comb begin
      state_nx  = state;
      streak_nx = wr_streak;
      unique case (state)
         IDLE: begin
            // Streak only matters while a read is waiting
            if (!rd_ok)
               streak_nx = 8'd0;
            if (wr_ok && (!rd_ok || wr_room)) begin
               state_nx = WR_D0;
               if (rd_ok)
                  streak_nx = wr_streak + 8'd1;
            end else if (rd_ok) begin
               state_nx  = RD_CMD;
               streak_nx = 8'd0;
            end
         end
         WR_D0:  if (app_wdf_rdy) state_nx = WR_D1;
         WR_D1:  if (app_wdf_rdy) state_nx = WR_CMD;
         WR_CMD: if (app_rdy)     state_nx = IDLE;
         RD_CMD: if (app_rdy)     state_nx = IDLE;
         default:                 state_nx = IDLE;
      endcase
   end

   // App-side outputs and FIFO pops, decoded from state and rdy
   always_comb begin
      app_addr     = '0;
      app_cmd      = 3'b000;
      app_en       = 1'b0;
      app_wdf_data = 64'd0;
      app_wdf_mask = 8'h00;
      app_wdf_wren = 1'b0;
      app_wdf_end  = 1'b0;
      get_wr_adx   = 1'b0;
      get_wr_data  = 1'b0;
      get_rd_req   = 1'b0;
      unique case (state)
         WR_D0: begin
            app_wdf_wren = 1'b1;
            app_wdf_data = wr_data_in[63:0];
         end
         WR_D1: begin
            app_wdf_wren = 1'b1;
            app_wdf_end  = 1'b1;
            app_wdf_data = wr_data_in[127:64];
            get_wr_data  = app_wdf_rdy;
         end
         WR_CMD: begin
            app_en     = 1'b1;
            app_addr   = wr_adx_in;
            get_wr_adx = app_rdy;
         end
         RD_CMD: begin
            app_en     = 1'b1;
            app_cmd    = 3'b001;
            app_addr   = rd_adx_in;
            get_rd_req = app_rdy;
         end
         default: ;
      endcase
   end

   assign busy = (state != IDLE);

`ifdef DDR_DISPATCH_STATS_EN
   logic stall;

   assign stall = (app_en & ~app_rdy) | (app_wdf_wren & ~app_wdf_rdy);

   // Free-running event counters, wrap at 2^32
   always_ff @(posedge clk) begin
      if (!resetn) begin
         stat_wr_cnt    <= 32'd0;
         stat_rd_cnt    <= 32'd0;
         stat_stall_cnt <= 32'd0;
      end else begin
         if (get_wr_adx) stat_wr_cnt    <= stat_wr_cnt + 32'd1;
         if (get_rd_req) stat_rd_cnt    <= stat_rd_cnt + 32'd1;
         if (stall)      stat_stall_cnt <= stat_stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ddr_cmd_dispatch.sv
// tb_ddr_cmd_dispatch: directed bench for ddr_cmd_dispatch.
// FIFOs are modelled with queues; outputs sampled on the falling edge.
module tb_ddr_cmd_dispatch;

   localparam int AW = 27;

   logic          clk = 1'b0;
   logic          resetn;
   logic [AW-1:0] wr_adx_in, rd_adx_in, app_addr;
   logic [127:0]  wr_data_in;
   logic          has_wr_adx, has_wr_data, has_rd_req;
   logic          get_wr_adx, get_wr_data, get_rd_req;
   logic [2:0]    app_cmd;
   logic          app_en, app_rdy;
   logic [63:0]   app_wdf_data;
   logic [7:0]    app_wdf_mask;
   logic          app_wdf_wren, app_wdf_end, app_wdf_rdy;
   logic          busy;
`ifdef DDR_DISPATCH_STATS_EN
   logic [31:0]   stat_wr_cnt, stat_rd_cnt, stat_stall_cnt;
`endif

   always #5 clk = ~clk;

   ddr_cmd_dispatch #(.WR_BURST_MAX(2), .ADDR_W(AW)) dut (
      .clk(clk), .resetn(resetn),
      .wr_adx_in(wr_adx_in), .wr_data_in(wr_data_in),
      .has_wr_adx(has_wr_adx), .has_wr_data(has_wr_data),
      .get_wr_adx(get_wr_adx), .get_wr_data(get_wr_data),
      .rd_adx_in(rd_adx_in), .has_rd_req(has_rd_req),
      .get_rd_req(get_rd_req),
      .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
      .app_rdy(app_rdy), .app_wdf_data(app_wdf_data),
      .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren),
      .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
      .busy(busy)
`ifdef DDR_DISPATCH_STATS_EN
     ,.stat_wr_cnt(stat_wr_cnt), .stat_rd_cnt(stat_rd_cnt),
      .stat_stall_cnt(stat_stall_cnt)
`endif
   );

   logic [AW-1:0] waq[$];
   logic [127:0]  wdq[$];
   logic [AW-1:0] raq[$];

   int n_chk = 0, n_fail = 0;
   int n_gwd = 0, n_gwa = 0, n_grd = 0;
   int ncmd = 0, en_cyc = 0, act_cyc = 0, excl_viol = 0;
   logic [7:0]    grants = '0;
   logic [AW-1:0] last_addr = '0;
   logic [63:0]   last_hi = '0;

   logic          o_en, o_wren, o_end, o_busy, o_acc;
   logic          o_gwd, o_gwa, o_grd;
   logic [2:0]    o_cmd;
   logic [AW-1:0] o_addr;
   logic [63:0]   o_data;
   logic [7:0]    o_mask;

   localparam logic [127:0] D1 =
      {64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555};
   localparam logic [127:0] D5 =
      {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210};

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic refresh();
      has_wr_adx  = waq.size() > 0;
      has_wr_data = wdq.size() > 0;
      has_rd_req  = raq.size() > 0;
      wr_adx_in   = has_wr_adx  ? waq[0] : '0;
      wr_data_in  = has_wr_data ? wdq[0] : '0;
      rd_adx_in   = has_rd_req  ? raq[0] : '0;
   endtask

   // One clock: observe at negedge, apply pops just after posedge
   task automatic tick();
      @(negedge clk);
      o_en   = app_en;   o_wren = app_wdf_wren; o_end  = app_wdf_end;
      o_busy = busy;     o_cmd  = app_cmd;      o_addr = app_addr;
      o_data = app_wdf_data; o_mask = app_wdf_mask;
      o_gwd  = get_wr_data;  o_gwa = get_wr_adx; o_grd = get_rd_req;
      o_acc  = app_en & app_rdy;
      if (app_en && app_wdf_wren) excl_viol++;
      if (app_en) en_cyc++;
      if (app_en || app_wdf_wren || busy) act_cyc++;
      if (o_acc) begin
         grants    = {grants[6:0], app_cmd == 3'b000};
         last_addr = app_addr;
         ncmd++;
      end
      if (app_wdf_wren && app_wdf_end && app_wdf_rdy)
         last_hi = app_wdf_data;
      @(posedge clk);
      #1;
      if (o_gwd) begin n_gwd++; if (wdq.size() > 0) void'(wdq.pop_front()); end
      if (o_gwa) begin n_gwa++; if (waq.size() > 0) void'(waq.pop_front()); end
      if (o_grd) begin n_grd++; if (raq.size() > 0) void'(raq.pop_front()); end
      refresh();
   endtask

   task automatic run_cmds(input int n, input int budget);
      int target;
      target = ncmd + n;
      for (int i = 0; i < budget && ncmd < target; i++) tick();
   endtask

   int a0, g0, w0, d0, c0, hold;

   initial begin
      resetn = 1'b0; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
      refresh();
      repeat (3) tick();
      chk("rst_ctl", {o_en, o_wren, o_end, o_gwd, o_gwa, o_grd, o_busy}, 0);
      chk("rst_cmd", o_cmd, 0);
      chk("rst_addr", o_addr, 0);
      chk("rst_data", {o_data, o_mask}, 0);
      resetn = 1'b1;
      tick();

      // Single write
      waq.push_back(27'h40); wdq.push_back(D1); refresh();
      tick();
      chk("w_idle", o_busy, 0);
      tick();
      chk("w_d0", {o_wren, o_end, o_en, o_gwd}, 4'b1000);
      chk("w_d0_data", o_data, 64'h5555_5555_5555_5555);
      chk("w_mask", o_mask, 0);
      tick();
      chk("w_d1", {o_wren, o_end, o_en, o_gwd}, 4'b1101);
      chk("w_d1_data", o_data, 64'hAAAA_AAAA_AAAA_AAAA);
      tick();
      chk("w_cmd", {o_en, o_wren, o_gwa, o_cmd}, 6'b101000);
      chk("w_addr", o_addr, 27'h40);
      tick();
      chk("w_done", o_busy, 0);
      chk("w_pops", {n_gwd[7:0], n_gwa[7:0]}, 16'h0101);

      // Single read with 3 stall cycles
      app_rdy = 1'b0; en_cyc = 0;
      raq.push_back(27'h100); refresh();
      tick();
      tick();
      chk("r_cmd", {o_en, o_cmd, o_grd}, 5'b10010);
      chk("r_addr", o_addr, 27'h100);
      tick();
      tick();
      chk("r_hold", {o_en, o_cmd, o_grd}, 5'b10010);
      chk("r_hold_addr", o_addr, 27'h100);
      app_rdy = 1'b1;
      tick();
      chk("r_acc", {o_en, o_grd}, 2'b11);
      tick();
      chk("r_en_cyc", en_cyc, 4);
      chk("r_pops", n_grd, 1);

      // Starvation guard with WR_BURST_MAX = 2
      grants = '0; c0 = ncmd;
      for (int i = 0; i < 5; i++) begin
         waq.push_back(27'h200 + 27'(i)); wdq.push_back(128'(i));
      end
      raq.push_back(27'h300); raq.push_back(27'h301);
      refresh();
      run_cmds(7, 80);
      chk("arb_cnt", ncmd - c0, 7);
      chk("arb_order", grants[6:0], 7'b1101101);
      chk("arb_last", last_addr, 27'h204);
      tick();

      // Address without data is not eligible
      a0 = act_cyc; c0 = ncmd;
      waq.push_back(27'h480); refresh();
      repeat (10) tick();
      chk("nodata_idle", act_cyc - a0, 0);
      wdq.push_back(D5); refresh();
      run_cmds(1, 20);
      chk("nodata_cmd", ncmd - c0, 1);
      chk("nodata_addr", last_addr, 27'h480);
      chk("nodata_hi", last_hi, D5[127:64]);
      tick();

      // Reset while stalled in WR_D1
      w0 = n_gwd; d0 = n_gwa;
      waq.push_back(27'h5A0); wdq.push_back(D5); refresh();
      tick();
      tick();
      app_wdf_rdy = 1'b0;
      tick();
      chk("mr_d1", {o_wren, o_end, o_gwd}, 3'b110);
      resetn = 1'b0;
      tick();
      tick();
      chk("mr_zero", {o_en, o_wren, o_end, o_busy, o_gwd, o_gwa}, 0);
      chk("mr_zdata", {o_data, o_addr}, 0);
      chk("mr_nopop", {n_gwd - w0, n_gwa - d0}, 0);
      resetn = 1'b1; app_wdf_rdy = 1'b1;
      tick();
      tick();
      chk("mr_reissue", {o_wren, o_end}, 2'b10);
      chk("mr_d0_data", o_data, D5[63:0]);
      run_cmds(1, 20);
      chk("mr_addr", last_addr, 27'h5A0);
      chk("mr_pops", {n_gwd - w0, n_gwa - d0}, {32'd1, 32'd1});
      tick();

`ifdef DDR_DISPATCH_STATS_EN
      // Counters over 3 writes and 2 reads, 2 stall cycles per command
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      c0 = ncmd; hold = 0;
      for (int i = 0; i < 3; i++) begin
         waq.push_back(27'h600 + 27'(i)); wdq.push_back(128'(i));
      end
      raq.push_back(27'h700); raq.push_back(27'h701);
      refresh();
      for (int i = 0; i < 120 && ncmd < c0 + 5; i++) begin
         app_rdy = !(app_en && hold < 2);
         tick();
         if (o_acc) hold = 0;
         else if (o_en) hold++;
      end
      app_rdy = 1'b1;
      tick();
      chk("st_cmds", ncmd - c0, 5);
      chk("st_wr", stat_wr_cnt, 3);
      chk("st_rd", stat_rd_cnt, 2);
      chk("st_stall", stat_stall_cnt, 10);
`endif

      chk("excl", excl_viol, 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
